icache_downstream_responder: RTL

Synthesizable responder for the icache downstream refill interface. It accepts refill requests on the downstream_txreq channel and returns full cache lines on the downstream_rxdat channel after a fixed latency. Lines are returned in order as multi-beat bursts tagged with the request entry_id. The block acts as the memory/L2 side when the icache is simulated or emulated standalone.

---
 rtl/icache_downstream_responder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/icache_downstream_responder.sv
// Memory-side responder for the icache refill interface: queues line requests and
// returns them in order as BEATS-beat bursts. Optional macro: ICACHE_DS_RANDOM_BACKPRESSURE_EN.
module icache_downstream_responder #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned BEATS   = 2,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       downstream_txreq_vld,
  output logic                       downstream_txreq_rdy,
  input  logic [ADDR_W-1:0]          downstream_txreq_pld,
  input  logic [ID_W-1:0]            downstream_txreq_entry_id,
  output logic                       downstream_rxdat_vld,
  input  logic                       downstream_rxdat_rdy,
  output logic [DATA_W-1:0]          downstream_rxdat_pld,
  output logic [ID_W-1:0]            downstream_rxdat_entry_id,
  output logic                       downstream_rxdat_last,
  output logic [$clog2(QDEPTH):0]    outstanding_cnt
);

  localparam int unsigned WORDS  = DATA_W / 32;
  localparam int unsigned LINE_B = BEATS * DATA_W / 8;
  localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_B - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   pld_q, pld_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                last_q, last_d;
  logic                rdy_q, rdy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;

  logic [ADDR_W-1:0]   q_addr [QDEPTH];
  logic [ID_W-1:0]     q_id   [QDEPTH];
  logic [7:0]          q_cd   [QDEPTH];

  logic accept_c;
  logic pop_c;
  logic head_ready_c;
  logic hold_c;
  logic rdy_gate_c;

`ifdef ICACHE_DS_RANDOM_BACKPRESSURE_EN
  // 16-bit Fibonacci LFSR, taps 16,14,13,11
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign hold_c     = (lfsr_q[3:2] == 2'b00);
  // rdy is registered, so gate it with the value the LFSR will hold next cycle
  assign rdy_gate_c = (lfsr_d[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign hold_c     = 1'b0;
  assign rdy_gate_c = 1'b1;
`endif

  // Build one beat: 32-bit word k of beat b is line + 4*(b*WORDS + k)
  function automatic logic [DATA_W-1:0] beat_data(input logic [ADDR_W-1:0] line,
                                                  input logic [BEAT_W-1:0] beat);
    logic [DATA_W-1:0] d;
    logic [31:0]       base;
    d    = '0;
    base = 32'(line);
    for (int k = 0; k < WORDS; k++) begin
      d[k*32 +: 32] = base + ((32'(beat) * 32'(WORDS) + 32'(k)) << 2);
    end
    return d;
  endfunction

  assign accept_c     = downstream_txreq_vld && rdy_q;
  assign head_ready_c = (cnt_q != '0) && (q_cd[rd_ptr_q] == 8'd0);

  // Next-state, response datapath and queue bookkeeping
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    vld_d    = vld_q;
    pld_d    = pld_q;
    id_d     = id_q;
    last_d   = last_q;
    pop_c    = 1'b0;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdy_d    = rdy_q;

    case (state_q)
      IDLE: begin
        if (head_ready_c && !hold_c) begin
          state_d = SEND;
          beat_d  = '0;
          vld_d   = 1'b1;
          pld_d   = beat_data(q_addr[rd_ptr_q], '0);
          id_d    = q_id[rd_ptr_q];
          last_d  = (BEATS == 1);
        end
      end
      SEND: begin
        if (downstream_rxdat_rdy) begin
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            pop_c   = 1'b1;
            state_d = IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            pld_d  = beat_data(q_addr[rd_ptr_q], beat_q + BEAT_W'(1));
            last_d = ((beat_q + BEAT_W'(1)) == BEAT_W'(BEATS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)    rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({accept_c, pop_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // A slot freed by this cycle's pop becomes visible to the requester next cycle
    rdy_d = (cnt_d != CNT_W'(QDEPTH)) && rdy_gate_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      vld_q    <= 1'b0;
      pld_q    <= '0;
      id_q     <= '0;
      last_q   <= 1'b0;
      rdy_q    <= 1'b1;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      vld_q    <= vld_d;
      pld_q    <= pld_d;
      id_q     <= id_d;
      last_q   <= last_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage; every countdown decrements each cycle except the slot being loaded
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_addr[i] <= '0;
        q_id[i]   <= '0;
        q_cd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (accept_c && (PTR_W'(i) == wr_ptr_q)) begin
          q_addr[i] <= downstream_txreq_pld & LINE_MASK;
          q_id[i]   <= downstream_txreq_entry_id;
          q_cd[i]   <= 8'(LATENCY);
        end else if (q_cd[i] != 8'd0) begin
          q_cd[i]   <= q_cd[i] - 8'd1;
        end
      end
    end
  end

  assign downstream_txreq_rdy      = rdy_q;
  assign downstream_rxdat_vld      = vld_q;
  assign downstream_rxdat_pld      = pld_q;
  assign downstream_rxdat_entry_id = id_q;
  assign downstream_rxdat_last     = last_q;
  assign outstanding_cnt           = cnt_q;

endmodule
